// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory -- pipeline memory stage.
//
// Turns the MEM-stage instruction into at most one data-bus transaction and
// registers the writeback-stage fields. A three-state controller
// (idle / busy / done) sequences aligned loads and stores over a simple
// req/ack data bus. Misaligned accesses never reach the bus. They pass
// straight through with the register write suppressed and an alignment
// error flag raised.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   alu_data_mem        ALU result: byte address for accesses, else wb value
//   mem_we_mem          store request
//   reg_d_we_mem        destination register write enable
//   reg_d_addr_mem      destination register index
//   reg_d_data_sel_mem  1 = writeback value comes from memory (load)
//   reg_t_data_mem      store data
//   dmem_req            data-bus request (held for the whole busy phase)
//   dmem_we             data-bus write strobe
//   dmem_addr           data-bus address (aligned, taken from the ALU result)
//   dmem_wdata          data-bus write data
//   dmem_rdata          data-bus read data, valid with dmem_ack
//   dmem_ack            data-bus completion pulse
//   mem_stall           combinational stall to upstream stages
//   reg_d_we_wb         registered writeback enable
//   reg_d_addr_wb       registered writeback index
//   reg_d_data_wb       registered writeback data
//   mem_align_err_wb    registered misaligned-access flag
// ---------------------------------------------------------------------------
module memory (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_data_mem,
  input  logic        mem_we_mem,
  input  logic        reg_d_we_mem,
  input  logic [4:0]  reg_d_addr_mem,
  input  logic        reg_d_data_sel_mem,
  input  logic [31:0] reg_t_data_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        reg_d_we_wb,
  output logic [4:0]  reg_d_addr_wb,
  output logic [31:0] reg_d_data_wb,
  output logic        mem_align_err_wb
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state;
  logic [31:0] rdata_q;

  logic access;
  logic misaligned;
  logic start;

  // Loads and stores both count as accesses. Only word-aligned ones go to the bus.
  assign access     = mem_we_mem | reg_d_data_sel_mem;
  assign misaligned = |alu_data_mem[1:0];
  assign start      = access & ~misaligned;

  // Stall covers the accept cycle and every busy cycle. The done cycle releases
  // the pipeline so the held instruction retires with the captured read data.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      StIdle:  mem_stall = start;
      StBusy:  mem_stall = 1'b1;
      StDone:  mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
  end

  // Controller with registered bus outputs. The bus fields are latched on
  // accept and stay constant until the ack, because the busy state never
  // writes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StBusy;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we_mem;
            dmem_addr  <= alu_data_mem;
            dmem_wdata <= reg_t_data_mem;
          end
        end
        StBusy: begin
          // No timeout: wait as long as the bus takes.
          if (dmem_ack) begin
            state    <= StDone;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rdata_q  <= dmem_rdata;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state    <= StIdle;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Writeback register. A stalled cycle inserts a bubble and keeps the
  // address and data fields unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_d_we_wb      <= 1'b0;
      reg_d_addr_wb    <= 5'd0;
      reg_d_data_wb    <= 32'h0;
      mem_align_err_wb <= 1'b0;
    end else if (mem_stall) begin
      reg_d_we_wb      <= 1'b0;
      mem_align_err_wb <= 1'b0;
    end else begin
      reg_d_we_wb      <= reg_d_we_mem & ~misaligned;
      reg_d_addr_wb    <= reg_d_addr_mem;
      reg_d_data_wb    <= reg_d_data_sel_mem ? rdata_q : alu_data_mem;
      mem_align_err_wb <= access & misaligned;
    end
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 alu_data_mem  input  32  ALU result; the byte address for loads/stores, or the writeback value otherwise.
REQ-004 mem_we_mem  input  1  store request.
REQ-005 reg_d_we_mem  input  1  destination register write enable.
REQ-006 reg_d_addr_mem  input  5  destination register index.
REQ-007 reg_d_data_sel_mem  input  1  1 = load (writeback value comes from memory), 0 = ALU value.
REQ-008 reg_t_data_mem  input  32  store data.
REQ-009 dmem_req  output  1  data-bus request.
REQ-010 dmem_we  output  1  data-bus write strobe.
REQ-011 dmem_addr  output  32  data-bus word address.
REQ-012 dmem_wdata  output  32  data-bus write data.
REQ-013 dmem_rdata  input  32  data-bus read data; valid with dmem_ack.
REQ-014 dmem_ack  input  1  data-bus completion, one cycle.
REQ-015 mem_stall  output  1  combinational; upstream SHALL hold all *_mem inputs stable while it is high.
REQ-016 reg_d_we_wb  output  1  registered writeback enable.
REQ-017 reg_d_addr_wb  output  5  registered writeback index.
REQ-018 reg_d_data_wb  output  32  registered writeback data.
REQ-019 mem_align_err_wb  output  1  registered misaligned-access flag.

Function
REQ-020 An access SHALL be defined as mem_we_mem | reg_d_data_sel_mem; a misaligned access is one with alu_data_mem[1:0] != 0.
REQ-021 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-022 IDLE with an aligned access: mem_stall=1 in that cycle; latch address, reg_t_data_mem and mem_we_mem; go to BUSY.
REQ-023 IDLE with no access, or with a misaligned access: mem_stall=0; remain in IDLE.
REQ-024 BUSY: dmem_req=1, with dmem_addr/dmem_we/dmem_wdata driven from the latches and held stable until ack.
REQ-025 BUSY with dmem_ack=0: mem_stall=1; remain in BUSY (no timeout).
REQ-026 BUSY with dmem_ack=1: mem_stall=1; capture dmem_rdata; go to DONE.
REQ-027 DONE: dmem_req=0 and mem_stall=0; go to IDLE.
REQ-028 dmem_ack SHALL be ignored outside BUSY.
REQ-029 Whenever mem_stall=0, the writeback registers SHALL load on the rising edge:
  - reg_d_we_wb = reg_d_we_mem & !misaligned
  - reg_d_addr_wb = reg_d_addr_mem
  - reg_d_data_wb = captured rdata if reg_d_data_sel_mem, else alu_data_mem
  - mem_align_err_wb = access & misaligned
REQ-030 Whenever mem_stall=1, the writeback registers SHALL load a bubble: reg_d_we_wb=0, mem_align_err_wb=0, addr/data unchanged.
REQ-031 Latency: a non-access instruction SHALL reach the wb outputs 1 cycle after it is presented.
REQ-032 An aligned access SHALL complete in 3+N cycles, where N is the number of BUSY cycles with ack low.
REQ-033 A misaligned access SHALL issue no bus request, SHALL not stall, and SHALL suppress the register write.
REQ-034 When both mem_we_mem and reg_d_data_sel_mem are high, dmem_we SHALL be 1 and the writeback data SHALL be the returned dmem_rdata.
REQ-035 Back-to-back accesses: the second access SHALL be accepted in the cycle after DONE (IDLE), with no gap cycle in which dmem_req is high.

Reset
REQ-036 When rst_n=0 at a rising edge, the block SHALL:
  - set the FSM to IDLE
  - clear dmem_req, dmem_we, reg_d_we_wb and mem_align_err_wb
  - clear dmem_addr, dmem_wdata, reg_d_addr_wb, reg_d_data_wb and the rdata capture to 0
REQ-037 Reset asserted during BUSY SHALL abandon the access; a dmem_ack arriving after reset SHALL be ignored.
REQ-038 mem_stall SHALL be 0 in the first cycle after reset release when no access is presented.

Verification
REQ-039 ALU op (alu_data_mem=0x1234, reg_d_we=1, addr=5, no access) -> next cycle: reg_d_we_wb=1, addr_wb=5, data_wb=0x1234; mem_stall never asserts.
REQ-040 Load from 0x100 with ack after 2 wait cycles, rdata=0xDEADBEEF, dest 7 -> mem_stall high for 4 cycles; dmem_req high for 3 cycles with addr=0x100 and we=0; then reg_d_we_wb=1, addr_wb=7, data_wb=0xDEADBEEF.
REQ-041 Store to 0x204 with data 0xCAFEF00D and immediate ack -> exactly one BUSY cycle with dmem_we=1, addr=0x204, wdata=0xCAFEF00D; total 3 cycles; reg_d_we_wb=0.
REQ-042 Load from 0x102 -> no dmem_req; next cycle mem_align_err_wb=1 and reg_d_we_wb=0; no stall.
REQ-043 rst_n low during BUSY, then ack pulsed 1 cycle after release -> FSM in IDLE; dmem_req=0; no writeback; ack has no effect.
REQ-044 Two consecutive loads (0x10, then 0x14; immediate acks) -> two distinct request windows separated by the DONE and IDLE cycles; both writebacks correct and in order.
